// File: rtl/op_pipe_pkg.sv
// Shared types, parameter limits and width helpers for the op_pipe operand pipeline.
package op_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  localparam int WIDTH_MIN  = 4;
  localparam int WIDTH_MAX  = 64;
  localparam int CUT_W_MIN  = 1;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

  // Packed payload is {res1, res2, cut, comb}.
  function automatic int payload_width(input int width, input int cut_w);
    return 2 * (width + 1) + cut_w + 2 * width;
  endfunction

endpackage

// File: rtl/op_pipe_stage.sv
// One valid/ready register slice of the op_pipe pipeline; holds while stalled, loads when empty or draining.
module op_pipe_stage
  import op_pipe_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  logic load;

  assign load = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/op_pipe.sv
// op_pipe top: accumulator, per-transaction result computation and a STAGES-deep register pipeline.
// Define OP_PIPE_SAT_EN to make the ACC mode saturate instead of wrapping.
module op_pipe
  import op_pipe_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          CUT_W     = 10,
  parameter int          STAGES    = 2,
  parameter int unsigned CONST_VAL = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     op1,
  input  logic [WIDTH-1:0]     op2,
  input  logic [WIDTH-1:0]     op3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH:0]       res1,
  output logic [WIDTH:0]       res2,
  output logic [CUT_W-1:0]     cut,
  output logic [2*WIDTH-1:0]   comb,
  output logic [2*WIDTH-1:0]   const_word
);

  localparam int DW = payload_width(WIDTH, CUT_W);
  localparam logic [2*WIDTH-1:0] CONST_WORD = (2*WIDTH)'(CONST_VAL);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || CUT_W < CUT_W_MIN || CUT_W > WIDTH ||
      STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_param
    $error("op_pipe: parameter out of range");
  end

  mode_e            mode_sel;
  logic             accept;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH:0]   res1_d;
  logic [WIDTH:0]   res2_d;
  logic [DW-1:0]    payload;
  logic [STAGES-1:0] stage_vld;
  logic [STAGES:0]   stage_rdy;
  logic [DW-1:0]    stage_data [STAGES];

  assign mode_sel   = mode_e'(mode);
  assign accept     = in_valid && in_ready;
  assign const_word = CONST_WORD;

`ifdef OP_PIPE_SAT_EN
  logic [WIDTH+1:0] acc_sum;

  always_comb begin
    acc_sum  = {1'b0, acc} + {2'b00, op1};
    acc_next = acc_sum[WIDTH+1] ? '1 : acc_sum[WIDTH:0];
  end
`else
  always_comb begin
    acc_next = acc + {1'b0, op1};
  end
`endif

  always_comb begin
    res1_d = '0;
    res2_d = {1'b0, op2} + {1'b0, op3};
    case (mode_sel)
      MODE_ADD: res1_d = {1'b0, op1} + {1'b0, op2};
      MODE_SUB: res1_d = {1'b0, op1} - {1'b0, op2};
      MODE_ACC: res1_d = acc_next;
      default:  res1_d = '0;
    endcase
    payload = {res1_d, res2_d, op1[CUT_W-1:0], op1, op2};
  end

  // The accumulator only moves on an accepted transaction, so a stalled ACC cannot double-count.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (accept) begin
      if (mode_sel == MODE_ACC) begin
        acc <= acc_next;
      end else if (mode_sel == MODE_CLR) begin
        acc <= '0;
      end
    end
  end

  // Stage i may load when it is empty or everything downstream of it can move.
  always_comb begin
    stage_rdy         = '0;
    stage_rdy[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      stage_rdy[i] = !stage_vld[i] || stage_rdy[i+1];
    end
  end

  assign in_ready = stage_rdy[0];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic          up_valid;
    logic [DW-1:0] up_data;

    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = payload;
    end else begin : g_link
      assign up_valid = stage_vld[i-1];
      assign up_data  = stage_data[i-1];
    end

    op_pipe_stage #(
      .DW(DW)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (up_valid),
      .in_data  (up_data),
      .out_ready(stage_rdy[i+1]),
      .out_valid(stage_vld[i]),
      .out_data (stage_data[i])
    );
  end

  assign out_valid = stage_vld[STAGES-1];
  assign {res1, res2, cut, comb} = stage_data[STAGES-1];

endmodule

// File: tb/tb_op_pipe.sv
// Scoreboard bench for op_pipe (WIDTH=32, CUT_W=10, STAGES=2, CONST_VAL=32); honours OP_PIPE_SAT_EN.
module tb_op_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [31:0] op1, op2, op3;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] res1, res2;
  logic [9:0]  cut;
  logic [63:0] comb;
  logic [63:0] const_word;

  typedef struct {
    logic [32:0] res1;
    logic [32:0] res2;
    logic [9:0]  cut;
    logic [63:0] comb;
  } exp_t;

  exp_t        expQ[$];
  logic [32:0] modelAcc;
  int          checkCount;
  int          errorCount;

  op_pipe #(
    .WIDTH(32), .CUT_W(10), .STAGES(2), .CONST_VAL(32)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .op1(op1), .op2(op2), .op3(op3), .out_valid(out_valid), .out_ready(out_ready),
    .res1(res1), .res2(res2), .cut(cut), .comb(comb), .const_word(const_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Reference model: result of one accepted transaction and its effect on the accumulator.
  task automatic pushExpected(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c);
    exp_t        e;
    logic [33:0] s;
    e.res2 = {1'b0, b} + {1'b0, c};
    e.cut  = a[9:0];
    e.comb = {a, b};
    case (m)
      2'd0: e.res1 = {1'b0, a} + {1'b0, b};
      2'd1: e.res1 = {1'b0, a} - {1'b0, b};
      2'd2: begin
        s = {1'b0, modelAcc} + {2'b00, a};
`ifdef OP_PIPE_SAT_EN
        modelAcc = s[33] ? 33'h1_FFFF_FFFF : s[32:0];
`else
        modelAcc = s[32:0];
`endif
        e.res1 = modelAcc;
      end
      default: begin
        modelAcc = '0;
        e.res1   = '0;
      end
    endcase
    expQ.push_back(e);
  endtask

  // Offer one transaction (called just after a falling edge) and hold it until accepted.
  task automatic applyStimulus(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c);
    int waitCycles;
    waitCycles = 0;
    in_valid = 1'b1;
    mode = m; op1 = a; op2 = b; op3 = c;
    #1;
    while (!in_ready && waitCycles < 50) begin
      @(negedge clk);
      #1;
      waitCycles++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 128'(in_ready), 128'(1));
    end else begin
      pushExpected(m, a, b, c);
    end
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Output monitor: compare every output handshake against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_out", 128'(1), 128'(0));
      end else begin
        e = expQ.pop_front();
        checkOutput("res1", 128'(res1), 128'(e.res1));
        checkOutput("res2", 128'(res2), 128'(e.res2));
        checkOutput("cut",  128'(cut),  128'(e.cut));
        checkOutput("comb", 128'(comb), 128'(e.comb));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   waitCycles;
    logic takeIt;
    checkCount = 0;
    errorCount = 0;
    modelAcc   = '0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mode = 2'd0; op1 = '0; op2 = '0; op3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_in_ready",  128'(in_ready),  128'(1));
    checkOutput("rst_const",     128'(const_word), 128'(32));
    checkOutput("rst_res1",      128'(res1), 128'(0));
    checkOutput("rst_res2",      128'(res2), 128'(0));
    checkOutput("rst_comb",      128'(comb), 128'(0));

    // ADD with carry out; result must appear exactly two cycles after acceptance.
    applyStimulus(2'd0, 32'hFFFF_FFFF, 32'h1, 32'h2);
    idleCycles(0);
    #1;
    checkOutput("lat_early", 128'(out_valid), 128'(0));
    @(negedge clk);
    #1;
    checkOutput("lat_valid", 128'(out_valid), 128'(1));
    checkOutput("add_res1",  128'(res1), 128'(33'h1_0000_0000));
    checkOutput("add_res2",  128'(res2), 128'(33'h3));
    checkOutput("add_cut",   128'(cut),  128'(10'h3FF));
    checkOutput("add_comb",  128'(comb), 128'(64'hFFFF_FFFF_0000_0001));
    idleCycles(2);

    applyStimulus(2'd1, 32'd3, 32'd5, 32'd0);
    applyStimulus(2'd1, 32'd5, 32'd3, 32'd0);
    idleCycles(3);
    checkOutput("sub_drained", 128'(expQ.size()), 128'(0));

    // Back-to-back accumulation, clear, and restart.
    applyStimulus(2'd2, 32'd10, 32'd0, 32'd0);
    applyStimulus(2'd2, 32'd20, 32'd0, 32'd0);
    applyStimulus(2'd2, 32'd30, 32'd0, 32'd0);
    applyStimulus(2'd3, 32'd0,  32'd0, 32'd0);
    applyStimulus(2'd2, 32'd7,  32'd0, 32'd0);
    idleCycles(4);

    // Backpressure: two ADDs fill the pipe, third is refused while out_ready is low.
    out_ready = 1'b0;
    applyStimulus(2'd0, 32'd100, 32'd1, 32'd1);
    applyStimulus(2'd0, 32'd200, 32'd2, 32'd2);
    in_valid = 1'b1; mode = 2'd0; op1 = 32'd300; op2 = 32'd3; op3 = 32'd3;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp_in_ready",  128'(in_ready),  128'(0));
      checkOutput("bp_out_valid", 128'(out_valid), 128'(1));
      checkOutput("bp_hold_res1", 128'(res1), 128'(expQ[0].res1));
      checkOutput("bp_hold_comb", 128'(comb), 128'(expQ[0].comb));
      @(negedge clk);
    end
    out_ready = 1'b1;
    applyStimulus(2'd0, 32'd300, 32'd3, 32'd3);
    idleCycles(4);
    checkOutput("bp_drained", 128'(expQ.size()), 128'(0));

    // Accumulator overflow: wraps to 1, or sticks at all-ones when saturating.
    applyStimulus(2'd3, 32'd0, 32'd0, 32'd0);
    applyStimulus(2'd2, 32'hFFFF_FFFF, 32'd0, 32'd0);
    applyStimulus(2'd2, 32'hFFFF_FFFF, 32'd0, 32'd0);
    applyStimulus(2'd2, 32'd1, 32'd0, 32'd0);
    applyStimulus(2'd2, 32'd2, 32'd0, 32'd0);
    applyStimulus(2'd2, 32'd0, 32'd0, 32'd0);
    applyStimulus(2'd3, 32'd0, 32'd0, 32'd0);
    applyStimulus(2'd2, 32'd4, 32'd0, 32'd0);
    idleCycles(4);

    // Reset while transactions are in flight: they vanish and acc restarts from 0.
    out_ready = 1'b0;
    applyStimulus(2'd2, 32'd50, 32'd0, 32'd0);
    applyStimulus(2'd0, 32'd1, 32'd1, 32'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expQ.delete();
    modelAcc = '0;
    #1;
    checkOutput("rst_mid_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_mid_ready", 128'(in_ready),  128'(1));
    out_ready = 1'b1;
    idleCycles(3);
    applyStimulus(2'd2, 32'd7, 32'd0, 32'd0);
    idleCycles(4);

    // Random traffic with random output stalls.
    for (int c = 0; c < 300; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        mode = 2'($urandom_range(0, 3));
        op1 = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 1000));
        op2 = $urandom;
        op3 = $urandom;
        in_valid = 1'b1;
      end
      #1;
      takeIt = in_valid && in_ready;
      if (takeIt) pushExpected(mode, op1, op2, op3);
      @(negedge clk);
      if (takeIt) in_valid = 1'b0;
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    waitCycles = 0;
    while (expQ.size() != 0 && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    @(negedge clk);
    checkOutput("final_drain", 128'(expQ.size()), 128'(0));
    checkOutput("final_const", 128'(const_word), 128'(32));

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
